// File: rtl/vfifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vfifo_ctrl_pkg
// Shared types and helpers for the vector FIFO replay controller.
//   rd_state_t : read-side sequencer states
//   beats()    : number of FIFO beats needed to move one whole vector
// -----------------------------------------------------------------------------
package vfifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REWIND = 2'd2,
    DONE   = 2'd3
  } rd_state_t;

  function automatic int beats(input int vec_elems, input int per_beat);
    return vec_elems / per_beat;
  endfunction

endpackage

// File: rtl/vfifo_replay_ctrl_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-Max up-counter with a synchronous clear.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   inc     : advance by one
//   clr     : force count to 0 (wins over inc)
//   count   : current value, 0..Max-1
//   wrap    : inc while count == Max-1 (the increment that returns to 0)
// -----------------------------------------------------------------------------
module wrap_counter
  import vfifo_ctrl_pkg::*;
#(
  parameter int Max = 2,
  parameter int W   = $clog2(Max + 1)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;

  assign count = count_q;
  assign wrap  = inc & (count_q == W'(Max - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= wrap ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/vfifo_replay_ctrl.sv
// -----------------------------------------------------------------------------
// vfifo_replay_ctrl
// Sequencer for one vector FIFO: write-side flow control and read-side replay.
// Each complete vector resident in the FIFO is streamed Repeats times, with a
// one-cycle read-pointer rewind between passes, and then its slot is released.
//
// Ports:
//   clk_in, rst_in   : clock, synchronous active-high reset
//   wr_valid/wr_ready: upstream write handshake; fifo_wr_en = wr_valid & wr_ready
//   rd_req           : downstream consumes the current beat
//   beat_valid/first/last : read beat framing; fifo_rd_en = beat_valid & rd_req
//   fifo_ptr_rst     : one-cycle rewind of the FIFO read pointer
//   pass_idx         : current pass, 0-based
//   vec_done         : one-cycle pulse when a vector's final pass completes
//   occupancy        : complete vectors resident
//   wr_stall_cnt, rd_stall_cnt : saturating stall counters, present only when
//                      VFIFO_REPLAY_PERF_EN is defined
// -----------------------------------------------------------------------------
module vfifo_replay_ctrl
  import vfifo_ctrl_pkg::*;
#(
  parameter int VecElements      = 16,
  parameter int ElementsPerWrite = 1,
  parameter int ElementsPerRead  = 4,
  parameter int Depth            = 2,
  parameter int Repeats          = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         fifo_wr_en,
  input  logic                         rd_req,
  output logic                         beat_valid,
  output logic                         beat_first,
  output logic                         beat_last,
  output logic                         fifo_rd_en,
  output logic                         fifo_ptr_rst,
  output logic [$clog2(Repeats+1)-1:0] pass_idx,
  output logic                         vec_done,
  output logic [$clog2(Depth+1)-1:0]   occupancy
`ifdef VFIFO_REPLAY_PERF_EN
  ,
  output logic [31:0]                  wr_stall_cnt,
  output logic [31:0]                  rd_stall_cnt
`endif
);

  localparam int WrBeats = beats(VecElements, ElementsPerWrite);
  localparam int RdBeats = beats(VecElements, ElementsPerRead);
  localparam int PW      = $clog2(Repeats + 1);
  localparam int OW      = $clog2(Depth + 1);
  localparam int WBW     = $clog2(WrBeats + 1);
  localparam int RBW     = $clog2(RdBeats + 1);

  rd_state_t    state_q;
  logic         beat_valid_q;
  logic         ptr_rst_q;
  logic         vec_done_q;
  logic [OW-1:0] occupancy_q, occupancy_d;

  logic [WBW-1:0] wr_beat;
  logic           wr_complete;
  logic [RBW-1:0] rd_beat;
  logic           rd_wrap;
  logic           pass_wrap;

  // ---------------- write side ----------------
  // A partially written vector already owns a slot, so it may always finish.
  assign wr_ready   = (wr_beat != '0) | (occupancy_q < OW'(Depth));
  assign fifo_wr_en = wr_valid & wr_ready;

  wrap_counter #(.Max(WrBeats), .W(WBW)) u_wr_beat (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (fifo_wr_en),
    .clr    (1'b0),
    .count  (wr_beat),
    .wrap   (wr_complete)
  );

  // ---------------- read side counters ----------------
  assign fifo_rd_en = beat_valid_q & rd_req;

  wrap_counter #(.Max(RdBeats), .W(RBW)) u_rd_beat (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (fifo_rd_en),
    .clr    (state_q != STREAM),
    .count  (rd_beat),
    .wrap   (rd_wrap)
  );

  // Advances on the accepted last beat of each pass; its wrap marks the
  // final pass, which sends the FSM to DONE instead of REWIND.
  wrap_counter #(.Max(Repeats), .W(PW)) u_pass (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (rd_wrap),
    .clr    (state_q == IDLE),
    .count  (pass_idx),
    .wrap   (pass_wrap)
  );

  // ---------------- read FSM with registered outputs ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      beat_valid_q <= 1'b0;
      ptr_rst_q    <= 1'b0;
      vec_done_q   <= 1'b0;
    end else begin
      ptr_rst_q  <= 1'b0;
      vec_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (occupancy_q != '0) begin
            state_q      <= STREAM;
            beat_valid_q <= 1'b1;
          end
        end
        STREAM: begin
          if (pass_wrap) begin
            state_q      <= DONE;
            beat_valid_q <= 1'b0;
            vec_done_q   <= 1'b1;
          end else if (rd_wrap) begin
            state_q      <= REWIND;
            beat_valid_q <= 1'b0;
            ptr_rst_q    <= 1'b1;
          end
        end
        REWIND: begin
          state_q      <= STREAM;
          beat_valid_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          beat_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- occupancy ----------------
  // vec_done_q is high exactly during the DONE cycle, when the slot is freed.
  always_comb begin
    occupancy_d = occupancy_q;
    case ({wr_complete, vec_done_q})
      2'b10:   occupancy_d = occupancy_q + 1'b1;
      2'b01:   occupancy_d = occupancy_q - 1'b1;
      default: occupancy_d = occupancy_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign beat_valid   = beat_valid_q;
  assign beat_first   = beat_valid_q & (rd_beat == '0);
  assign beat_last    = beat_valid_q & (rd_beat == RBW'(RdBeats - 1));
  assign fifo_ptr_rst = ptr_rst_q;
  assign vec_done     = vec_done_q;
  assign occupancy    = occupancy_q;

  a_occ_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    (wr_complete && !vec_done_q) |-> (occupancy_q < OW'(Depth)));
  a_occ_no_underflow: assert property (@(posedge clk_in) disable iff (rst_in)
    vec_done_q |-> (occupancy_q != '0));

`ifdef VFIFO_REPLAY_PERF_EN
  logic [31:0] wr_stall_q, wr_stall_d;
  logic [31:0] rd_stall_q, rd_stall_d;

  always_comb begin
    wr_stall_d = wr_stall_q;
    rd_stall_d = rd_stall_q;
    if (wr_valid && !wr_ready && (wr_stall_q != '1)) wr_stall_d = wr_stall_q + 1'b1;
    if (beat_valid_q && !rd_req && (rd_stall_q != '1)) rd_stall_d = rd_stall_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      wr_stall_q <= wr_stall_d;
      rd_stall_q <= rd_stall_d;
    end
  end

  assign wr_stall_cnt = wr_stall_q;
  assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_vfifo_replay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vfifo_replay_ctrl
// Randomized bench for vfifo_replay_ctrl (VecElements=16, ElementsPerWrite=1,
// ElementsPerRead=4, Depth=2, Repeats=3). The reference model keeps a count of
// written beats, a count of resident vectors and, for the vector being replayed,
// a queue of the read-side cycles still to come (beats, rewinds, release).
// Stall counters are checked as well when VFIFO_REPLAY_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_vfifo_replay_ctrl;

  localparam int VE  = 16;
  localparam int EPW = 1;
  localparam int EPR = 4;
  localparam int DEP = 2;
  localparam int REP = 3;
  localparam int WB  = VE / EPW;
  localparam int RB  = VE / EPR;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in = 1'b1;
  logic wr_valid = 1'b0;
  logic rd_req = 1'b0;
  logic wr_ready, fifo_wr_en, beat_valid, beat_first, beat_last;
  logic fifo_rd_en, fifo_ptr_rst, vec_done;
  logic [$clog2(REP+1)-1:0] pass_idx;
  logic [$clog2(DEP+1)-1:0] occupancy;
`ifdef VFIFO_REPLAY_PERF_EN
  logic [31:0] wr_stall_cnt, rd_stall_cnt;
`endif

  vfifo_replay_ctrl #(
    .VecElements(VE), .ElementsPerWrite(EPW), .ElementsPerRead(EPR),
    .Depth(DEP), .Repeats(REP)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .fifo_wr_en   (fifo_wr_en),
    .rd_req       (rd_req),
    .beat_valid   (beat_valid),
    .beat_first   (beat_first),
    .beat_last    (beat_last),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_ptr_rst (fifo_ptr_rst),
    .pass_idx     (pass_idx),
    .vec_done     (vec_done),
    .occupancy    (occupancy)
`ifdef VFIFO_REPLAY_PERF_EN
    ,
    .wr_stall_cnt (wr_stall_cnt),
    .rd_stall_cnt (rd_stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  localparam int K_BEAT = 0;
  localparam int K_REW  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int pass_no;
    int beat;
  } step_t;

  step_t sched[$];
  int    m_wb, m_occ, m_wr_stall, m_rd_stall, vec_cnt;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cnt_rd, cnt_wr, cnt_ptr, cnt_done;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    m_wb = 0; m_occ = 0; m_wr_stall = 0; m_rd_stall = 0;
  endtask

  task automatic load_vector();
    for (int p = 0; p < REP; p++) begin
      for (int b = 0; b < RB; b++) sched.push_back('{K_BEAT, p, b});
      sched.push_back('{(p < REP - 1) ? K_REW : K_DONE, p, 0});
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic cycle(input bit wv, input bit rr);
    bit    e_wr_ready, e_wen, e_bv, e_first, e_last, e_ptr, e_done, wc;
    step_t h;
    @(posedge clk_in);
    #1;
    wr_valid = wv;
    rd_req   = rr;
    @(negedge clk_in);

    e_wr_ready = (m_wb != 0) || (m_occ < DEP);
    e_wen      = wv && e_wr_ready;
    h          = '{-1, 0, 0};
    if (sched.size() > 0) h = sched[0];
    e_bv    = (h.kind == K_BEAT);
    e_first = e_bv && (h.beat == 0);
    e_last  = e_bv && (h.beat == RB - 1);
    e_ptr   = (h.kind == K_REW);
    e_done  = (h.kind == K_DONE);

    chk("wr_ready",   wr_ready,     e_wr_ready);
    chk("fifo_wr_en", fifo_wr_en,   e_wen);
    chk("beat_valid", beat_valid,   e_bv);
    chk("beat_first", beat_first,   e_first);
    chk("beat_last",  beat_last,    e_last);
    chk("fifo_rd_en", fifo_rd_en,   e_bv && rr);
    chk("ptr_rst",    fifo_ptr_rst, e_ptr);
    chk("vec_done",   vec_done,     e_done);
    chk("occupancy",  occupancy,    m_occ);
    if (e_bv) chk("pass_idx", pass_idx, h.pass_no);
`ifdef VFIFO_REPLAY_PERF_EN
    chk("wr_stall_cnt", wr_stall_cnt, m_wr_stall);
    chk("rd_stall_cnt", rd_stall_cnt, m_rd_stall);
`endif
    cnt_rd   += int'(fifo_rd_en);
    cnt_wr   += int'(fifo_wr_en);
    cnt_ptr  += int'(fifo_ptr_rst);
    cnt_done += int'(vec_done);

    if (wv && !e_wr_ready) m_wr_stall++;
    if (e_bv && !rr) m_rd_stall++;
    wc = e_wen && (m_wb == WB - 1);
    if (e_wen) m_wb = (m_wb + 1) % WB;
    if (sched.size() == 0) begin
      if (m_occ > 0) load_vector();
    end else if (!e_bv || rr) begin
      void'(sched.pop_front());
    end
    if (e_done) begin
      vec_cnt++;
      $display("vector %0d released at t=%0t", vec_cnt, $time);
    end
    m_occ = m_occ + int'(wc) - int'(e_done);
  endtask

  task automatic clear_counts();
    cnt_rd = 0; cnt_wr = 0; cnt_ptr = 0; cnt_done = 0;
  endtask

  // One reset cycle, then a direct check of the post-reset outputs.
  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1; wr_valid = 1'b0; rd_req = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    chk("rst_wr_ready",   wr_ready,     1);
    chk("rst_wr_en",      fifo_wr_en,   0);
    chk("rst_beat_valid", beat_valid,   0);
    chk("rst_first",      beat_first,   0);
    chk("rst_last",       beat_last,    0);
    chk("rst_rd_en",      fifo_rd_en,   0);
    chk("rst_ptr_rst",    fifo_ptr_rst, 0);
    chk("rst_vec_done",   vec_done,     0);
    chk("rst_pass_idx",   pass_idx,     0);
    chk("rst_occupancy",  occupancy,    0);
`ifdef VFIFO_REPLAY_PERF_EN
    chk("rst_wr_stall",   wr_stall_cnt, 0);
    chk("rst_rd_stall",   rd_stall_cnt, 0);
`endif
  endtask

  task automatic rand_phase(input int wp, input int rp, input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(99) < wp, $urandom_range(99) < rp);
  endtask

  initial begin
    bit found;
    model_reset();
    vec_cnt = 0;
    clear_counts();
    do_reset();

    // One vector, reader always ready.
    for (int i = 0; i < WB; i++) cycle(1'b1, 1'b1);
    chk("s1_occ_after_write", m_occ, 1);
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1);
    chk("s1_rd_beats",   cnt_rd,   RB * REP);
    chk("s1_ptr_rst",    cnt_ptr,  REP - 1);
    chk("s1_vec_done",   cnt_done, 1);
    chk("s1_occ_final",  occupancy, 0);

    // Reader stalled, writer pushing: fills exactly Depth vectors.
    clear_counts();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
    chk("s2_accepted", cnt_wr, WB * DEP);
    chk("s2_wr_ready", wr_ready, 0);
    chk("s2_occ",      occupancy, DEP);

    // Reader toggling every cycle, no writes.
    clear_counts();
    for (int i = 0; i < 120; i++) cycle(1'b0, i[0]);
    chk("s3_vec_done", cnt_done, 2);
    chk("s3_rd_beats", cnt_rd,   2 * RB * REP);

    // Randomized traffic at different pressure levels.
    rand_phase(70, 70, 400);
    rand_phase(30, 90, 400);
    rand_phase(90, 30, 400);
    rand_phase(50, 50, 400);

    // Reset in the middle of pass 1, beat 2.
    found = 1'b0;
    for (int i = 0; i < 800 && !found; i++) begin
      cycle(1'b1, $urandom_range(99) < 60);
      if (sched.size() > 0 && sched[0].kind == K_BEAT &&
          sched[0].pass_no == 1 && sched[0].beat == 2) found = 1'b1;
    end
    chk("s5_reached_mid_pass", found, 1);
    do_reset();

    rand_phase(60, 60, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vfifo_replay_ctrl.md
Name: vfifo_replay_ctrl

Overview:
- Sequencer for one vector FIFO instance (write-side flow control plus read-side replay).
- Accepts element beats from an upstream producer and drives the FIFO write enable.
- Counts complete vectors resident in the FIFO.
- Streams each resident vector to a downstream consumer Repeats times, e.g. one pass per weight row of a reservoir matrix-vector product, rewinding the read pointer between passes, then releases the slot.

Parameters:
- VecElements, 16, elements per vector
- ElementsPerWrite, 1, elements per FIFO write beat; must divide VecElements
- ElementsPerRead, 4, elements per FIFO read beat; must divide VecElements
- Depth, 2, vector slots in the FIFO; >=1
- Repeats, 8, read passes per vector; >=1

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- wr_valid  in  1  upstream has a write beat
- wr_ready  out  1  controller accepts a write beat this cycle
- fifo_wr_en  out  1  to FIFO wr_en; = wr_valid & wr_ready
- rd_req  in  1  downstream consumes the current read beat
- beat_valid  out  1  FIFO rd_data holds a valid beat
- beat_first  out  1  first beat of a pass
- beat_last  out  1  last beat of a pass
- fifo_rd_en  out  1  to FIFO rd_en; = beat_valid & rd_req
- fifo_ptr_rst  out  1  to FIFO ptr_rst; one-cycle rewind pulse to the current vector start
- pass_idx  out  $clog2(Repeats+1)  current pass number, 0-based
- vec_done  out  1  one-cycle pulse when a vector's last pass completes
- occupancy  out  $clog2(Depth+1)  complete vectors resident

Behaviour:
- Derived constants: WrBeats = VecElements/ElementsPerWrite; RdBeats = VecElements/ElementsPerRead.
- Reset: all counters 0, state IDLE. Every output is 0 except wr_ready, which is 1 when Depth>=1.
- Reset mid-operation discards partial writes and in-progress passes; no fifo_ptr_rst pulse is emitted during reset.
- Write side:
  - wr_beat counter runs 0..WrBeats-1 and advances on fifo_wr_en.
  - When it wraps, occupancy increments (vector complete).
  - wr_ready = (wr_beat != 0) | (occupancy < Depth). A partially written vector already holds a reserved slot.
- Read FSM, states IDLE, STREAM, REWIND, DONE:
  - IDLE: go to STREAM when occupancy > 0; pass_idx <= 0, rd_beat <= 0.
  - STREAM: beat_valid = 1. rd_data is combinational, so there is zero latency from beat_valid to data.
    - rd_beat advances on fifo_rd_en.
    - beat_first = (rd_beat == 0); beat_last = (rd_beat == RdBeats-1).
    - On fifo_rd_en with beat_last: go to REWIND if pass_idx < Repeats-1, else go to DONE.
    - rd_req low means hold; nothing advances.
  - REWIND (1 cycle): fifo_ptr_rst = 1, beat_valid = 0; pass_idx++, rd_beat <= 0; go to STREAM.
  - DONE (1 cycle): vec_done = 1; occupancy decrements; go to IDLE. IDLE re-enters STREAM on the next cycle when occupancy > 0 after the decrement.
- Simultaneous write-complete and DONE in the same cycle: occupancy unchanged.
- Repeats == 1: REWIND is never entered.
- fifo_wr_en and fifo_rd_en are fully independent; a write may land in the same cycle as a read beat or a rewind.
- occupancy never exceeds Depth and never underflows; both are assertion targets.

Optional Feature:
- Macro: VFIFO_REPLAY_PERF_EN.
- When defined: adds two output ports, each 32 bits, saturating, cleared on reset.
  - wr_stall_cnt counts cycles with wr_valid & ~wr_ready.
  - rd_stall_cnt counts cycles with beat_valid & ~rd_req.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package vfifo_ctrl_pkg holds:
  - enum rd_state_t {IDLE, STREAM, REWIND, DONE}
  - function beats(vec_elems, per_beat), returning vec_elems/per_beat
- One sub-module, wrap_counter:
  - parameter Max
  - inputs inc, clr
  - outputs count and wrap, where wrap = inc & count==Max-1
  - used for wr_beat, rd_beat and pass_idx.

Test Plan:
Configuration for all scenarios: VecElements=16, ElementsPerWrite=1, ElementsPerRead=4, Depth=2, Repeats=3.
1. Write 16 beats, rd_req held 1.
   - occupancy = 1 after beat 16.
   - 12 fifo_rd_en pulses, with beat_first/beat_last framing each group of 4.
   - fifo_ptr_rst pulses exactly twice.
   - vec_done once; occupancy returns to 0.
2. rd_req low, wr_valid held 1 for 40 cycles.
   - Exactly 32 beats accepted; wr_ready = 0 from then on; occupancy = 2.
3. rd_req toggled 1/0 every cycle during STREAM.
   - Only asserted cycles advance rd_beat; total 12 beats; the pass sequence is unchanged.
4. Complete a second vector's write on the same cycle as DONE of the first.
   - occupancy stays 1; STREAM restarts with pass_idx = 0.
5. Assert rst_in mid-pass (pass_idx=1, rd_beat=2).
   - Next cycle: all outputs 0, wr_ready = 1, occupancy = 0.
6. VFIFO_REPLAY_PERF_EN build, rd_req held 0 for 10 cycles while in STREAM.
   - rd_stall_cnt = 10.
